// File: rtl/axi_stream_pkt_buffer64.sv
// Store-and-forward packet buffer for the 64-bit AXI-Stream path in the mClk domain.
// Only complete, well-formed packets are forwarded. Malformed, oversize or
// overflowing packets are dropped without ever stalling the input.
module axi_stream_pkt_buffer64 #(
    parameter int unsigned DEPTH_LOG2    = 9,
    parameter int unsigned MAX_PKT_WORDS = 256
) (
    input  logic        mClk,
    input  logic        resetN,
    input  logic [63:0] sAxiStreamTdata,
    input  logic [7:0]  sAxiStreamTkeep,
    input  logic        sAxiStreamTlast,
    input  logic        sAxiStreamTvalid,
    output logic        sAxiStreamTready,
    output logic [63:0] mAxiStreamTdata,
    output logic [7:0]  mAxiStreamTkeep,
    output logic        mAxiStreamTlast,
    output logic        mAxiStreamTvalid,
    input  logic        mAxiStreamTready,
    output logic [15:0] pktCount,
    output logic [15:0] dropCount
);

    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned LW    = $clog2(MAX_PKT_WORDS + 1);

    typedef enum logic {ACCEPT, DISCARD} wrState_t;

    wrState_t        wrState;
    logic [PW-1:0]   wrPtr, wrCommit, rdPtr, freePtr;
    logic [LW-1:0]   pktLen;
    logic            readyReg;

    // Each entry is {tlast, tkeep, tdata}; tlast is kept alongside so packet
    // boundaries travel with the data through the RAM.
    logic [72:0]     mem [DEPTH];
    logic [72:0]     ramQ, holdQ, outWord;
    logic            rdValid, holdValid;

    logic            inBeat, full, lastKeepOk, badBeat, wrEn, dropEvent;
    logic            available, outValid, outPop, rdIssue;

    // Write-side qualification, read-issue decision and output-side handshake
    always_comb begin
        inBeat     = sAxiStreamTvalid & readyReg;
        full       = (PW'(wrPtr - freePtr) == PW'(DEPTH));
        lastKeepOk = (sAxiStreamTkeep != '0) &&
                     ((sAxiStreamTkeep & (sAxiStreamTkeep + 8'd1)) == '0);
        badBeat    = full || (pktLen == LW'(MAX_PKT_WORDS)) ||
                     (!sAxiStreamTlast && (sAxiStreamTkeep != '1)) ||
                     (sAxiStreamTlast && !lastKeepOk);
        wrEn       = inBeat && (wrState == ACCEPT) && !badBeat;
        dropEvent  = inBeat && sAxiStreamTlast &&
                     ((wrState == DISCARD) || badBeat);
        available  = (rdPtr != wrCommit);
        outValid   = holdValid | rdValid;
        outWord    = holdValid ? holdQ : ramQ;
        outPop     = outValid & mAxiStreamTready;
        // The RAM output register is the newer skid entry; a new read may only
        // be launched when it will be vacated at this edge.
        rdIssue    = available && !(holdValid && rdValid && !outPop);
    end

    assign sAxiStreamTready = readyReg;
    assign mAxiStreamTvalid = outValid;
    assign mAxiStreamTdata  = outWord[63:0];
    assign mAxiStreamTkeep  = outWord[71:64];
    assign mAxiStreamTlast  = outWord[72];

    // Write FSM: accept or discard packets, commit on good tlast, count drops
    always_ff @(posedge mClk or negedge resetN) begin
        if (!resetN) begin
            wrState   <= ACCEPT;
            wrPtr     <= '0;
            wrCommit  <= '0;
            pktLen    <= '0;
            readyReg  <= 1'b0;
            dropCount <= '0;
        end else begin
            readyReg <= 1'b1;
            if (inBeat) begin
                case (wrState)
                    ACCEPT: begin
                        if (badBeat) begin
                            wrPtr  <= wrCommit;
                            pktLen <= '0;
                            if (!sAxiStreamTlast) wrState <= DISCARD;
                        end else begin
                            wrPtr <= wrPtr + PW'(1);
                            if (sAxiStreamTlast) begin
                                wrCommit <= wrPtr + PW'(1);
                                pktLen   <= '0;
                            end else begin
                                pktLen <= pktLen + LW'(1);
                            end
                        end
                    end
                    DISCARD: begin
                        if (sAxiStreamTlast) wrState <= ACCEPT;
                    end
                    default: wrState <= ACCEPT;
                endcase
            end
            if (dropEvent && (dropCount != '1)) dropCount <= dropCount + 16'd1;
        end
    end

    // Packet RAM write port
    always_ff @(posedge mClk) begin
        if (wrEn) mem[wrPtr[DEPTH_LOG2-1:0]] <= {sAxiStreamTlast, sAxiStreamTkeep, sAxiStreamTdata};
    end

    // Synchronous RAM read into a two-entry skid (RAM register + hold register);
    // words are freed for the writer only once their output handshake completes
    always_ff @(posedge mClk or negedge resetN) begin
        if (!resetN) begin
            ramQ      <= '0;
            holdQ     <= '0;
            rdValid   <= 1'b0;
            holdValid <= 1'b0;
            rdPtr     <= '0;
            freePtr   <= '0;
            pktCount  <= '0;
        end else begin
            if (rdIssue) begin
                ramQ  <= mem[rdPtr[DEPTH_LOG2-1:0]];
                rdPtr <= rdPtr + PW'(1);
            end
            rdValid <= rdIssue | (rdValid & holdValid & ~outPop);
            if (!holdValid && rdValid && !outPop) begin
                holdQ     <= ramQ;
                holdValid <= 1'b1;
            end else if (holdValid && outPop) begin
                if (rdValid) holdQ <= ramQ;
                else         holdValid <= 1'b0;
            end
            if (outPop) freePtr <= freePtr + PW'(1);
            if (outPop && outWord[72] && (pktCount != '1)) pktCount <= pktCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_axi_stream_pkt_buffer64.sv
// Self-checking bench for axi_stream_pkt_buffer64: a packet-level model
// (pending packet, expected output word queue, occupancy count) checked every cycle.
module tb_axi_stream_pkt_buffer64;

    logic        mClk = 1'b0;
    logic        resetN;
    logic [63:0] sData;
    logic [7:0]  sKeep;
    logic        sLast, sValid, sReady;
    logic [63:0] mData;
    logic [7:0]  mKeep;
    logic        mLast, mValid, mReady;
    logic [15:0] pktCount, dropCount;

    axi_stream_pkt_buffer64 #(.DEPTH_LOG2(9), .MAX_PKT_WORDS(256)) dut (
        .mClk(mClk), .resetN(resetN),
        .sAxiStreamTdata(sData), .sAxiStreamTkeep(sKeep), .sAxiStreamTlast(sLast),
        .sAxiStreamTvalid(sValid), .sAxiStreamTready(sReady),
        .mAxiStreamTdata(mData), .mAxiStreamTkeep(mKeep), .mAxiStreamTlast(mLast),
        .mAxiStreamTvalid(mValid), .mAxiStreamTready(mReady),
        .pktCount(pktCount), .dropCount(dropCount)
    );

    always #5 mClk = ~mClk;

    int unsigned asserts = 0, fails = 0;
    int unsigned readyMode = 0;   // 0: ready high, 1: ready low, 2: random 50%

    // Behavioural model state
    logic [72:0]  expQ[$];
    logic [71:0]  pend[$];
    int unsigned  lastPos[$];
    int unsigned  held = 0, modelPkt = 0, modelDrop = 0, outBeats = 0, cyc = 0;
    int           latWatch = -1;
    bit           discard = 0, prevStall = 0, prevRstHi = 0, fullNow, okKeep, bad;
    logic [72:0]  prevOut, expW;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkW(input string nm, input logic [72:0] act, input logic [72:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output ready pattern, updated just after each active edge
    initial begin
        mReady = 1'b1;
        forever begin
            @(posedge mClk); #1;
            case (readyMode)
                0: mReady = 1'b1;
                1: mReady = 1'b0;
                default: mReady = ($urandom % 2) == 0;
            endcase
        end
    end

    // Model update and compare, sampled mid-cycle for the coming edge
    always @(negedge mClk) begin
        cyc++;
        if (!resetN) begin
            chk("rst_sready", 32'(sReady), 0);
            chk("rst_mvalid", 32'(mValid), 0);
            chkW("rst_mword", {mLast, mKeep, mData}, '0);
            chk("rst_pktCount", 32'(pktCount), 0);
            chk("rst_dropCount", 32'(dropCount), 0);
            expQ.delete(); pend.delete(); lastPos.delete();
            held = 0; modelPkt = 0; modelDrop = 0; outBeats = 0;
            discard = 0; prevStall = 0; prevRstHi = 0; latWatch = -1;
        end else begin
            if (prevRstHi) chk("sready_high", 32'(sReady), 1);
            if (prevStall) begin
                chk("stall_valid", 32'(mValid), 1);
                chkW("stall_word", {mLast, mKeep, mData}, prevOut);
            end
            chk("pktCount", 32'(pktCount), modelPkt);
            chk("dropCount", 32'(dropCount), modelDrop);
            if (latWatch >= 0 && mValid) begin
                chk("latency_le2", (cyc - 32'(latWatch) <= 2) ? 1 : 0, 1);
                latWatch = -1;
            end
            fullNow = (held + 32'(pend.size()) == 512);
            // Output side
            if (mValid && mReady) begin
                outBeats++;
                if (expQ.size() == 0) begin
                    chk("unexpected_out_beat", 1, 0);
                end else begin
                    expW = expQ.pop_front();
                    chkW("out_word", {mLast, mKeep, mData}, expW);
                    held--;
                    if (expW[72]) begin
                        lastPos.push_back(outBeats);
                        if (modelPkt < 65535) modelPkt++;
                    end
                end
            end
            // Input side
            if (sValid && sReady) begin
                if (discard) begin
                    if (sLast) begin
                        discard = 0;
                        if (modelDrop < 65535) modelDrop++;
                    end
                end else begin
                    okKeep = (sKeep == 8'h01) || (sKeep == 8'h03) || (sKeep == 8'h07) ||
                             (sKeep == 8'h0F) || (sKeep == 8'h1F) || (sKeep == 8'h3F) ||
                             (sKeep == 8'h7F) || (sKeep == 8'hFF);
                    bad = fullNow || (pend.size() == 256) ||
                          (!sLast && sKeep != 8'hFF) || (sLast && !okKeep);
                    if (bad) begin
                        pend.delete();
                        if (sLast) begin
                            if (modelDrop < 65535) modelDrop++;
                        end else begin
                            discard = 1;
                        end
                    end else if (sLast) begin
                        if (expQ.size() == 0 && !mValid) latWatch = int'(cyc);
                        foreach (pend[i]) expQ.push_back({1'b0, pend[i]});
                        expQ.push_back({1'b1, sKeep, sData});
                        held += 32'(pend.size()) + 1;
                        pend.delete();
                    end else begin
                        pend.push_back({sKeep, sData});
                    end
                end
            end
            prevStall = mValid && !mReady;
            prevOut   = {mLast, mKeep, mData};
            prevRstHi = 1;
        end
    end

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        sValid = 1'b1; sData = d; sKeep = k; sLast = l;
        @(posedge mClk); #1;
    endtask

    task automatic idle(input int unsigned n);
        sValid = 1'b0;
        repeat (n) begin @(posedge mClk); #1; end
    endtask

    // midKeep != 8'hFF makes the first word of a multi-word packet malformed
    task automatic sendPkt(input int unsigned len, input logic [7:0] lastKeep, input logic [7:0] midKeep);
        for (int unsigned i = 0; i < len; i++)
            beat({$urandom, $urandom}, (i == len - 1) ? lastKeep : ((i == 0) ? midKeep : 8'hFF),
                 (i == len - 1));
        sValid = 1'b0;
    endtask

    task automatic doReset();
        sValid = 1'b0;
        resetN = 1'b0;
        repeat (3) begin @(posedge mClk); #1; end
        resetN = 1'b1;
        repeat (2) begin @(posedge mClk); #1; end
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        sValid = 1'b0;
        while ((expQ.size() != 0 || mValid) && n < budget) begin
            @(posedge mClk); #1; n++;
        end
        chk("drain_within_budget", (n < budget) ? 1 : 0, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, test incomplete");
        $fatal(1, "watchdog");
    end

    logic [7:0] goodKeeps [8];
    logic [7:0] badKeeps  [3];
    int unsigned r, len;
    logic [7:0] lk, mk;

    initial begin
        goodKeeps = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        badKeeps  = '{8'h05, 8'h00, 8'h80};
        resetN = 1'b0; sValid = 1'b0; sData = '0; sKeep = '0; sLast = 1'b0;
        @(posedge mClk); #1;

        // 1: three packets back-to-back, full-rate output
        readyMode = 0;
        doReset();
        sendPkt(4, 8'h0F, 8'hFF);
        sendPkt(1, 8'h0F, 8'hFF);
        sendPkt(9, 8'h0F, 8'hFF);
        drain(100);
        chk("t1_pktCount", 32'(pktCount), 3);
        chk("t1_dropCount", 32'(dropCount), 0);
        chk("t1_outBeats", outBeats, 14);
        chk("t1_lastCount", 32'(lastPos.size()), 3);
        if (lastPos.size() == 3) begin
            chk("t1_last0", lastPos[0], 4);
            chk("t1_last1", lastPos[1], 5);
            chk("t1_last2", lastPos[2], 14);
        end

        // 2: oversize packet then a good one
        doReset();
        sendPkt(257, 8'hFF, 8'hFF);
        sendPkt(2, 8'hFF, 8'hFF);
        drain(100);
        chk("t2_pktCount", 32'(pktCount), 1);
        chk("t2_dropCount", 32'(dropCount), 1);
        chk("t2_outBeats", outBeats, 2);

        // 3: fill the buffer with output stalled, one extra packet overflows
        readyMode = 1;
        doReset();
        idle(2);
        for (int i = 0; i < 257; i++) sendPkt(2, 8'hFF, 8'hFF);
        idle(3);
        chk("t3_dropCount", 32'(dropCount), 1);
        chk("t3_pktCount_stalled", 32'(pktCount), 0);
        readyMode = 0;
        drain(2000);
        chk("t3_pktCount", 32'(pktCount), 256);
        chk("t3_outBeats", outBeats, 512);

        // 4: malformed keeps
        doReset();
        sendPkt(3, 8'hFF, 8'h7F);
        sendPkt(2, 8'h05, 8'hFF);
        idle(5);
        chk("t4_dropCount", 32'(dropCount), 2);
        chk("t4_outBeats", outBeats, 0);

        // 5: random stream with random back-pressure
        readyMode = 2;
        doReset();
        for (int p = 0; p < 1000; p++) begin
            r   = $urandom_range(99, 0);
            len = (r < 1) ? $urandom_range(260, 250) : $urandom_range(6, 1);
            lk  = goodKeeps[$urandom_range(7, 0)];
            mk  = 8'hFF;
            r   = $urandom_range(99, 0);
            if (r < 5) lk = badKeeps[$urandom_range(2, 0)];
            else if (r < 10) mk = 8'hFE;
            sendPkt(len, lk, mk);
            idle($urandom_range(2, 0));
        end
        drain(20000);

        // 6: reset mid-packet on both sides, then clean packet, then drop saturation
        doReset();
        sendPkt(20, 8'hFF, 8'hFF);
        idle(3);
        for (int i = 0; i < 4; i++) beat({$urandom, $urandom}, 8'hFF, 1'b0);
        doReset();
        readyMode = 0;
        sendPkt(3, 8'h0F, 8'hFF);
        drain(100);
        chk("t6_pktCount", 32'(pktCount), 1);
        chk("t6_dropCount", 32'(dropCount), 0);
        chk("t6_outBeats", outBeats, 3);
        for (int i = 0; i < 65540; i++) beat({$urandom, $urandom}, 8'h00, 1'b1);
        idle(3);
        chk("t6_dropSat", 32'(dropCount), 32'h0000_FFFF);
        chk("t6_pktAfterSat", 32'(pktCount), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
